// File: rtl/cr_prefix_fe_blk_buf.sv
// Prefix front-end block buffer: four 1 KB capture segments, a descriptor FIFO and a consumer read port.
// Optional statistics counters are built when CR_PREFIX_FE_BUF_STATS_EN is defined.
//
// Segment states:
//   state     | meaning
//   SEG_FREE  | empty, accepts writes from the front end
//   SEG_FILL  | at least one word captured, not yet committed
//   SEG_FULL  | committed, owned by the prefix engine until seg_free
module cr_prefix_fe_blk_buf #(
    parameter int SEG_WORDS  = 128,
    parameter int DESC_DEPTH = 4,
    localparam int AW = $clog2(SEG_WORDS),
    localparam int CW = $clog2(SEG_WORDS * 8 + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [63:0]   fe_char_in,
    input  logic [7:0]    fe_char_vbytes,
    input  logic [1:0]    fe_sel_1k,
    input  logic          fe_ctlr_1k_wr,
    input  logic          fe_ctlr_2k_wr,
    input  logic          fe_ctlr_3k_wr,
    input  logic          fe_ctlr_4k_wr,
    input  logic          fe_ctlr_eodb,
    output logic          fe_ready,
    output logic          blk_valid,
    input  logic          blk_ready,
    output logic [1:0]    blk_seg,
    output logic [CW-1:0] blk_bytes,
    output logic          blk_last,
    input  logic          rd_en,
    input  logic [1:0]    rd_seg,
    input  logic [AW-1:0] rd_addr,
    output logic [63:0]   rd_data,
    input  logic [3:0]    seg_free,
    output logic          err_ovfl,
    output logic [31:0]   stat_blks,
    output logic [31:0]   stat_bytes
);

    localparam int FW = $clog2(DESC_DEPTH);
    localparam logic [AW:0] PTR_MAX = (AW + 1)'(SEG_WORDS);

    typedef enum logic [1:0] {
        SEG_FREE = 2'd0,
        SEG_FILL = 2'd1,
        SEG_FULL = 2'd2
    } seg_state_t;

    seg_state_t    seg_state [4];
    logic [AW:0]   wptr      [4];
    logic [CW-1:0] bcnt      [4];
    logic          eodb_seen;

    logic [63:0]   mem [4 * SEG_WORDS];

    logic [1:0]    dq_seg   [DESC_DEPTH];
    logic [CW-1:0] dq_bytes [DESC_DEPTH];
    logic          dq_last  [DESC_DEPTH];
    logic [FW-1:0] dq_rd_ptr;
    logic [FW-1:0] dq_wr_ptr;
    logic [FW:0]   dq_cnt;

    function automatic logic [CW-1:0] popcount8(input logic [7:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int k = 0; k < 8; k++) begin
            c = c + CW'(v[k]);
        end
        return c;
    endfunction

    logic          wr_req;
    logic          wr_ok;
    logic [CW-1:0] wr_nbytes;
    logic [3:0]    cm_strobes;
    logic          cm_req;
    logic          cm_ok;
    logic [1:0]    cm_seg;
    logic          cm_last;
    logic [CW-1:0] cm_bytes;
    logic          fifo_full;
    logic          dq_pop;
    logic [3:0]    free_ok;
    logic          err_evt;

    assign wr_req    = |fe_char_vbytes;
    assign wr_nbytes = popcount8(fe_char_vbytes);
    assign wr_ok     = wr_req && (seg_state[fe_sel_1k] != SEG_FULL) && (wptr[fe_sel_1k] != PTR_MAX);

    assign cm_strobes = {fe_ctlr_4k_wr, fe_ctlr_3k_wr, fe_ctlr_2k_wr, fe_ctlr_1k_wr};
    assign cm_req     = |cm_strobes;

    always_comb begin
        cm_seg = 2'd0;
        if (cm_strobes[0]) begin
            cm_seg = 2'd0;
        end else if (cm_strobes[1]) begin
            cm_seg = 2'd1;
        end else if (cm_strobes[2]) begin
            cm_seg = 2'd2;
        end else if (cm_strobes[3]) begin
            cm_seg = 2'd3;
        end
    end

    // More than one strobe at once marks the end of the data block.
    assign cm_last   = ((cm_strobes & (cm_strobes - 4'd1)) != 4'd0) | fe_ctlr_eodb | eodb_seen;
    assign cm_bytes  = bcnt[cm_seg] + ((wr_ok && (fe_sel_1k == cm_seg)) ? wr_nbytes : '0);
    assign fifo_full = (dq_cnt == (FW + 1)'(DESC_DEPTH));
    assign cm_ok     = cm_req && (seg_state[cm_seg] != SEG_FULL) && !fifo_full;

    always_comb begin
        free_ok = '0;
        for (int i = 0; i < 4; i++) begin
            free_ok[i] = seg_free[i] && (seg_state[i] == SEG_FULL);
        end
    end

    assign err_evt = (wr_req && !wr_ok) || (cm_req && !cm_ok) || ((seg_free & ~free_ok) != 4'd0);

    assign blk_valid = (dq_cnt != '0);
    assign dq_pop    = blk_valid && blk_ready;
    assign blk_seg   = blk_valid ? dq_seg[dq_rd_ptr]   : '0;
    assign blk_bytes = blk_valid ? dq_bytes[dq_rd_ptr] : '0;
    assign blk_last  = blk_valid ? dq_last[dq_rd_ptr]  : 1'b0;

    assign fe_ready = (seg_state[fe_sel_1k] != SEG_FULL);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                seg_state[i] <= SEG_FREE;
                wptr[i]      <= '0;
                bcnt[i]      <= '0;
            end
            eodb_seen <= 1'b0;
            err_ovfl  <= 1'b0;
            dq_rd_ptr <= '0;
            dq_wr_ptr <= '0;
            dq_cnt    <= '0;
            rd_data   <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (cm_ok && (cm_seg == 2'(i))) begin
                    seg_state[i] <= SEG_FULL;
                    wptr[i]      <= '0;
                    bcnt[i]      <= '0;
                end else if (free_ok[i]) begin
                    seg_state[i] <= SEG_FREE;
                end else if (wr_ok && (fe_sel_1k == 2'(i))) begin
                    seg_state[i] <= SEG_FILL;
                    wptr[i]      <= wptr[i] + (AW + 1)'(1);
                    bcnt[i]      <= bcnt[i] + wr_nbytes;
                end
            end

            if (cm_ok) begin
                eodb_seen <= 1'b0;
            end else if (fe_ctlr_eodb) begin
                eodb_seen <= 1'b1;
            end

            if (err_evt) begin
                err_ovfl <= 1'b1;
            end

            if (cm_ok) begin
                dq_wr_ptr <= dq_wr_ptr + FW'(1);
            end
            if (dq_pop) begin
                dq_rd_ptr <= dq_rd_ptr + FW'(1);
            end
            if (cm_ok && !dq_pop) begin
                dq_cnt <= dq_cnt + (FW + 1)'(1);
            end else if (!cm_ok && dq_pop) begin
                dq_cnt <= dq_cnt - (FW + 1)'(1);
            end

            if (rd_en) begin
                rd_data <= mem[{rd_seg, rd_addr}];
            end
        end
    end

    // Storage arrays carry no reset; validity is tracked by pointers and counters.
    always_ff @(posedge clk) begin
        if (!rst && wr_ok) begin
            mem[{fe_sel_1k, wptr[fe_sel_1k][AW-1:0]}] <= fe_char_in;
        end
        if (!rst && cm_ok) begin
            dq_seg[dq_wr_ptr]   <= cm_seg;
            dq_bytes[dq_wr_ptr] <= cm_bytes;
            dq_last[dq_wr_ptr]  <= cm_last;
        end
    end

`ifdef CR_PREFIX_FE_BUF_STATS_EN
    logic [31:0] stat_blks_q;
    logic [31:0] stat_bytes_q;
    logic [32:0] stat_bytes_sum;

    assign stat_bytes_sum = {1'b0, stat_bytes_q} + 33'(cm_bytes);

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_blks_q  <= '0;
            stat_bytes_q <= '0;
        end else if (cm_ok) begin
            if (stat_blks_q != 32'hFFFF_FFFF) begin
                stat_blks_q <= stat_blks_q + 32'd1;
            end
            stat_bytes_q <= stat_bytes_sum[32] ? 32'hFFFF_FFFF : stat_bytes_sum[31:0];
        end
    end

    assign stat_blks  = stat_blks_q;
    assign stat_bytes = stat_bytes_q;
`else
    assign stat_blks  = '0;
    assign stat_bytes = '0;
`endif

endmodule

// File: tb/tb_cr_prefix_fe_blk_buf.sv
// Self-checking bench for cr_prefix_fe_blk_buf: directed scenarios then random traffic against a queue-based model.
module tb_cr_prefix_fe_blk_buf;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] fe_char_in;
    logic [7:0]  fe_char_vbytes;
    logic [1:0]  fe_sel_1k;
    logic        fe_ctlr_1k_wr, fe_ctlr_2k_wr, fe_ctlr_3k_wr, fe_ctlr_4k_wr;
    logic        fe_ctlr_eodb;
    logic        fe_ready;
    logic        blk_valid;
    logic        blk_ready;
    logic [1:0]  blk_seg;
    logic [10:0] blk_bytes;
    logic        blk_last;
    logic        rd_en;
    logic [1:0]  rd_seg;
    logic [6:0]  rd_addr;
    logic [63:0] rd_data;
    logic [3:0]  seg_free;
    logic        err_ovfl;
    logic [31:0] stat_blks;
    logic [31:0] stat_bytes;

    always #5 clk = ~clk;

    cr_prefix_fe_blk_buf dut (
        .clk(clk), .rst(rst),
        .fe_char_in(fe_char_in), .fe_char_vbytes(fe_char_vbytes), .fe_sel_1k(fe_sel_1k),
        .fe_ctlr_1k_wr(fe_ctlr_1k_wr), .fe_ctlr_2k_wr(fe_ctlr_2k_wr),
        .fe_ctlr_3k_wr(fe_ctlr_3k_wr), .fe_ctlr_4k_wr(fe_ctlr_4k_wr),
        .fe_ctlr_eodb(fe_ctlr_eodb), .fe_ready(fe_ready),
        .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_seg(blk_seg),
        .blk_bytes(blk_bytes), .blk_last(blk_last),
        .rd_en(rd_en), .rd_seg(rd_seg), .rd_addr(rd_addr), .rd_data(rd_data),
        .seg_free(seg_free), .err_ovfl(err_ovfl),
        .stat_blks(stat_blks), .stat_bytes(stat_bytes)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: segment contents as arrays, descriptors as a queue.
    typedef struct {
        int seg;
        int bytes;
        bit last;
    } desc_t;

    logic [63:0] m_mem [4][128];
    int          m_wcnt [4];
    int          m_bytes [4];
    bit          m_full [4];
    bit          m_eodb;
    bit          m_err;
    desc_t       m_q[$];
    logic [63:0] m_rd;
    longint      m_blks;
    longint      m_sbytes;

    task automatic model_step();
        bit    full_pre [4];
        int    qsize;
        bit    popv;
        bit    acc;
        int    cs;
        logic [3:0] strb;
        desc_t d;
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                m_wcnt[i] = 0; m_bytes[i] = 0; m_full[i] = 0;
            end
            m_eodb = 0; m_err = 0; m_q.delete(); m_rd = '0; m_blks = 0; m_sbytes = 0;
            return;
        end
        for (int i = 0; i < 4; i++) full_pre[i] = m_full[i];
        qsize = m_q.size();
        popv  = (qsize > 0) && blk_ready;
        acc   = 0;
        if (rd_en) m_rd = m_mem[rd_seg][rd_addr];
        if (fe_char_vbytes != 0) begin
            if (m_full[fe_sel_1k] || m_wcnt[fe_sel_1k] >= 128) begin
                m_err = 1;
            end else begin
                m_mem[fe_sel_1k][m_wcnt[fe_sel_1k]] = fe_char_in;
                m_wcnt[fe_sel_1k]++;
                m_bytes[fe_sel_1k] += $countones(fe_char_vbytes);
            end
        end
        strb = {fe_ctlr_4k_wr, fe_ctlr_3k_wr, fe_ctlr_2k_wr, fe_ctlr_1k_wr};
        if (strb != 0) begin
            cs = 0;
            while (!strb[cs]) cs++;
            if (full_pre[cs] || qsize == 4) begin
                m_err = 1;
            end else begin
                d.seg = cs; d.bytes = m_bytes[cs];
                d.last = ($countones(strb) > 1) || fe_ctlr_eodb || m_eodb;
                m_q.push_back(d);
                m_blks = (m_blks < 64'hFFFF_FFFF) ? m_blks + 1 : m_blks;
                m_sbytes = (m_sbytes + d.bytes > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_sbytes + d.bytes;
                m_wcnt[cs] = 0; m_bytes[cs] = 0; m_full[cs] = 1;
                acc = 1;
            end
        end
        if (acc) m_eodb = 0;
        else if (fe_ctlr_eodb) m_eodb = 1;
        for (int i = 0; i < 4; i++) begin
            if (seg_free[i]) begin
                if (full_pre[i]) m_full[i] = 0;
                else m_err = 1;
            end
        end
        if (popv) void'(m_q.pop_front());
    endtask

    task automatic check_all();
        logic [63:0] e_seg, e_bytes, e_last, e_sb, e_sy;
        e_seg = 0; e_bytes = 0; e_last = 0;
        if (m_q.size() > 0) begin
            e_seg = m_q[0].seg; e_bytes = m_q[0].bytes; e_last = m_q[0].last;
        end
`ifdef CR_PREFIX_FE_BUF_STATS_EN
        e_sb = m_blks; e_sy = m_sbytes;
`else
        e_sb = 0; e_sy = 0;
`endif
        chk("fe_ready", fe_ready, !m_full[fe_sel_1k]);
        chk("blk_valid", blk_valid, m_q.size() > 0);
        chk("blk_seg", blk_seg, e_seg);
        chk("blk_bytes", blk_bytes, e_bytes);
        chk("blk_last", blk_last, e_last);
        chk("err_ovfl", err_ovfl, m_err);
        chk("rd_data", rd_data, m_rd);
        chk("stat_blks", stat_blks, e_sb);
        chk("stat_bytes", stat_bytes, e_sy);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic idle();
        rst = 0; fe_char_in = '0; fe_char_vbytes = '0;
        fe_ctlr_1k_wr = 0; fe_ctlr_2k_wr = 0; fe_ctlr_3k_wr = 0; fe_ctlr_4k_wr = 0;
        fe_ctlr_eodb = 0; rd_en = 0; seg_free = '0;
    endtask

    task automatic wr(input logic [1:0] s, input logic [7:0] vb, input logic [63:0] d);
        fe_sel_1k = s; fe_char_vbytes = vb; fe_char_in = d;
        tick();
        idle();
    endtask

    logic [63:0] w0 [128];
    logic [1:0]  h_seg;
    logic [10:0] h_bytes;
    logic        h_last;

    initial begin
        idle();
        fe_sel_1k = 0; blk_ready = 0; rd_seg = 0; rd_addr = 0;
        rst = 1;
        tick();
        tick();
        rst = 0;
        tick();
        chk("rst_fe_ready", fe_ready, 1'b1);
        chk("rst_blk_valid", blk_valid, 1'b0);
        chk("rst_rd_data", rd_data, 64'd0);

        // Fill segment 0 completely, then close it.
        for (int i = 0; i < 128; i++) begin
            w0[i] = {$urandom, $urandom};
            wr(2'd0, 8'hFF, w0[i]);
        end
        fe_ctlr_1k_wr = 1;
        tick();
        idle();
        chk("tp1_valid", blk_valid, 1'b1);
        chk("tp1_seg", blk_seg, 2'd0);
        chk("tp1_bytes", blk_bytes, 11'd1024);
        chk("tp1_last", blk_last, 1'b0);
        fe_sel_1k = 0;
        #1;
        chk("tp1_fe_ready", fe_ready, 1'b0);

        // Partial segment 1 closed with multiple strobes.
        wr(2'd1, 8'hFF, {$urandom, $urandom});
        wr(2'd1, 8'hFF, {$urandom, $urandom});
        wr(2'd1, 8'h07, {$urandom, $urandom});
        fe_ctlr_2k_wr = 1; fe_ctlr_3k_wr = 1; fe_ctlr_4k_wr = 1;
        tick();
        idle();
        chk("tp2_err", err_ovfl, 1'b0);

        // Readback of seg0 word 5, then release seg0.
        rd_en = 1; rd_seg = 0; rd_addr = 7'd5;
        tick();
        idle();
        chk("tp3_rd_data", rd_data, w0[5]);
        seg_free = 4'b0001; fe_sel_1k = 0;
        tick();
        idle();
        chk("tp3_fe_ready", fe_ready, 1'b1);

        // Overflow seg2 and write into FULL seg1.
        for (int i = 0; i < 129; i++) wr(2'd2, 8'hFF, {$urandom, $urandom});
        chk("tp4_err_ovfl", err_ovfl, 1'b1);
        wr(2'd1, 8'hFF, 64'hDEAD_BEEF);
        fe_ctlr_3k_wr = 1;
        tick();
        idle();
        chk("tp4_err_sticky", err_ovfl, 1'b1);

        // Held descriptor must stay stable while blk_ready is low.
        h_seg = blk_seg; h_bytes = blk_bytes; h_last = blk_last;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("tp5_hold", {blk_seg, blk_bytes, blk_last}, {h_seg, h_bytes, h_last});
        end
        blk_ready = 1;
        tick();
        chk("tp5_pop1_seg", blk_seg, 2'd1);
        chk("tp5_pop1_bytes", blk_bytes, 11'd19);
        chk("tp5_pop1_last", blk_last, 1'b1);
        fe_ctlr_1k_wr = 1;
        tick();
        idle();
        chk("tp5_pushpop_seg", blk_seg, 2'd2);
        chk("tp5_pushpop_bytes", blk_bytes, 11'd1024);
        tick();
        chk("tp5_zero_commit", blk_bytes, 11'd0);
        tick();
        chk("tp5_drained", blk_valid, 1'b0);

        // Random traffic against the model.
        seg_free = 4'b1111;
        tick();
        idle();
        for (int c = 0; c < 4000; c++) begin
            int n;
            n = $urandom_range(0, 9);
            fe_sel_1k      = 2'($urandom_range(0, 3));
            fe_char_in     = {$urandom, $urandom};
            fe_char_vbytes = (n > 8) ? 8'h00 : 8'((16'h1 << n) - 16'h1);
            if ($urandom_range(0, 24) == 0) begin
                {fe_ctlr_4k_wr, fe_ctlr_3k_wr, fe_ctlr_2k_wr, fe_ctlr_1k_wr} = 4'($urandom_range(1, 15));
            end
            fe_ctlr_eodb = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 9) == 0) seg_free = 4'(1 << $urandom_range(0, 3));
            blk_ready = $urandom_range(0, 1);
            rd_en     = $urandom_range(0, 1);
            rd_seg    = 2'($urandom_range(0, 3));
            rd_addr   = 7'($urandom_range(0, 127));
            tick();
            idle();
        end

        // Reset in the middle of filling seg3.
        blk_ready = 0;
        rst = 1;
        tick();
        idle();
        fe_ctlr_1k_wr = 1;
        tick();
        idle();
        for (int i = 0; i < 40; i++) wr(2'd3, 8'hFF, {$urandom, $urandom});
        rst = 1;
        tick();
        idle();
        chk("tp6_blk_valid", blk_valid, 1'b0);
        chk("tp6_err", err_ovfl, 1'b0);
        chk("tp6_stat_blks", stat_blks, 32'd0);
        chk("tp6_stat_bytes", stat_bytes, 32'd0);
        for (int s = 0; s < 4; s++) begin
            fe_sel_1k = 2'(s);
            #1;
            chk("tp6_fe_ready", fe_ready, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
